// File: rtl/detect_sched.sv
// Frame scheduler: arbitrates 4 requesters, serialises the winner's byte MSB first into
// an overlapping "101" Mealy detector and counts matches. `ROUND_ROBIN_EN selects round-robin.
module detect_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] frame_bus,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        din_s,
  output logic        qout,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [3:0]  match_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant, StShift, StDone} state_e;
  typedef enum logic [1:0] {DetS0, DetS1, DetS10} det_e;

  state_e      state_q, state_d;
  det_e        det_q, det_d;
  logic [1:0]  win_q;
  logic [1:0]  arb_win;
  logic [7:0]  frame_q;
  logic [7:0]  frame_sel;
  logic [2:0]  cnt_q;
  logic [3:0]  match_cnt_q;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q;

  // Walk offsets high to low so the requester closest to the pointer wins.
  always_comb begin
    arb_win = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) arb_win = ptr_q + 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (state_q == StIdle && req != 4'd0) begin
      ptr_q <= arb_win + 2'd1;
    end
  end
`else
  always_comb begin
    arb_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) arb_win = 2'(i);
    end
  end
`endif

  assign frame_sel = frame_bus[{win_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    din_s   = 1'b0;
    qout    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req != 4'd0) state_d = StGrant;
      end
      StGrant: begin
        det_d   = DetS0;
        state_d = StShift;
      end
      StShift: begin
        din_s = frame_q[7];
        unique case (det_q)
          DetS0:  det_d = din_s ? DetS1 : DetS0;
          DetS1:  det_d = din_s ? DetS1 : DetS10;
          DetS10: begin
            if (din_s) begin
              qout  = 1'b1;
              det_d = DetS1;
            end else begin
              det_d = DetS0;
            end
          end
          default: det_d = DetS0;
        endcase
        if (cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      det_q       <= DetS0;
      win_q       <= 2'd0;
      frame_q     <= 8'd0;
      cnt_q       <= 3'd0;
      match_cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      unique case (state_q)
        StIdle: begin
          if (req != 4'd0) win_q <= arb_win;
        end
        StGrant: begin
          frame_q     <= frame_sel;
          cnt_q       <= 3'd0;
          match_cnt_q <= 4'd0;
        end
        StShift: begin
          frame_q <= {frame_q[6:0], 1'b0};
          cnt_q   <= cnt_q + 3'd1;
          if (qout) match_cnt_q <= match_cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign gnt       = busy ? (4'b0001 << win_q) : 4'b0000;
  assign done      = (state_q == StDone);
  assign done_id   = win_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched; build with or without +define+ROUND_ROBIN_EN.
module tb_detect_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] frame_bus;
  logic [3:0]  gnt;
  logic        busy, din_s, qout, done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;

  int checks = 0;
  int errors = 0;

  detect_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .frame_bus (frame_bus),
    .gnt       (gnt),
    .busy      (busy),
    .din_s     (din_s),
    .qout      (qout),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Starts in IDLE, ends in IDLE one cycle after DONE with req cleared.
  task automatic run_frame(input logic [3:0] r, input int id, input logic [7:0] f,
                           input logic [7:0] qexp, input logic [3:0] mexp, input bit drop);
    frame_bus = {4{~f}};
    frame_bus[8*id +: 8] = f;
    req = r;
    chk("idle_busy", busy, 0);
    step();
    chk("grant_gnt", gnt, 32'd1 << id);
    chk("grant_busy", busy, 1);
    chk("grant_din", din_s, 0);
    chk("grant_qout", qout, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        frame_bus = ~frame_bus;
        if (drop) req = 4'd0;
      end
      chk("shift_gnt", gnt, 32'd1 << id);
      chk("shift_din", din_s, f[7-i]);
      chk("shift_qout", qout, qexp[7-i]);
      chk("shift_done", done, 0);
    end
    step();
    chk("done", done, 1);
    chk("done_id", done_id, id);
    chk("done_match", match_cnt, mexp);
    chk("done_din", din_s, 0);
    chk("done_qout", qout, 0);
    req = 4'd0;
    step();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_gnt", gnt, 0);
    chk("match_hold", match_cnt, mexp);
  endtask

  int order[5];
  int nord;

  initial begin
    rst = 1'b1;
    req = 4'd0;
    frame_bus = 32'd0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_din", din_s, 0);
    chk("rst_qout", qout, 0);
    rst = 1'b0;
    step();
    chk("idle_hold", busy, 0);

    run_frame(4'b0001, 0, 8'b10101101, 8'b00101001, 4'd3, 1'b0);
    run_frame(4'b0100, 2, 8'hFF,       8'h00,       4'd0, 1'b0);
    run_frame(4'b1000, 3, 8'b00000101, 8'b00000001, 4'd1, 1'b0);
    run_frame(4'b1000, 3, 8'b01000000, 8'h00,       4'd0, 1'b0);
    run_frame(4'b0110, 1, 8'b10100000, 8'b00100000, 4'd1, 1'b0);
    run_frame(4'b0001, 0, 8'b01010100, 8'b00010100, 4'd2, 1'b1);

    // Reset during SHIFT cycle 4 aborts the frame.
    frame_bus = 32'h0000_00AD;
    req = 4'b0001;
    step();
    chk("rst_mid_gnt0", gnt, 4'b0001);
    for (int i = 0; i < 4; i++) step();
    chk("rst_mid_cnt_pre", match_cnt, 1);
    req = 4'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_match", match_cnt, 0);
    chk("rst_mid_done", done, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rst_mid_nodone", done, 0);
    end

`ifdef ROUND_ROBIN_EN
    order = '{0, 1, 2, 3, 0};
    nord = 5;
`else
    order = '{0, 0, 0, 0, 0};
    nord = 3;
`endif
    frame_bus = 32'hFFFF_FFFF;
    req = 4'b1111;
    for (int k = 0; k < nord; k++) begin
      step();
      chk("cont_gnt", gnt, 32'd1 << order[k]);
      for (int i = 0; i < 9; i++) step();
      chk("cont_done", done, 1);
      chk("cont_done_id", done_id, order[k]);
      step();
      chk("cont_idle", busy, 0);
    end
    req = 4'd0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_sched.md
DETECT_SCHED -- requirements
Module: detect_sched

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have `req`, input, 4 bits: one frame-request bit per requester 0..3.
REQ-004 The block SHALL have `frame_bus`, input, 32 bits: requester k's 8-bit frame on bits [8k+7:8k].
REQ-005 The block SHALL have `gnt`, output, 4 bits: one-hot grant, held from GRANT through DONE.
REQ-006 The block SHALL have `busy`, output, 1 bit: high in every non-IDLE state.
REQ-007 The block SHALL have `din_s`, output, 1 bit: serial bit currently driven into the detector.
REQ-008 The block SHALL have `qout`, output, 1 bit: Mealy detector output for the current bit.
REQ-009 The block SHALL have `done`, output, 1 bit: one-cycle pulse in DONE.
REQ-010 The block SHALL have `done_id`, output, 2 bits: index of the requester just served, valid with `done`.
REQ-011 The block SHALL have `match_cnt`, output, 4 bits: matches in the last frame; valid with `done` and held until the next GRANT.

Function
REQ-012 The block SHALL implement states IDLE, GRANT, SHIFT and DONE.
REQ-013 The IDLE->GRANT transition SHALL be taken when `req` != 0; the arbitration winner SHALL be registered.
REQ-014 IDLE SHALL hold when `req` == 0.
REQ-015 In GRANT (exactly 1 cycle), the block SHALL:
- assert `gnt`,
- latch the winner's 8-bit frame,
- clear `match_cnt` to 0,
- reset the detector to its start state so patterns never span frames.
REQ-016 SHIFT SHALL last exactly 8 cycles and drive the frame MSB first on `din_s`.
REQ-017 The internal Mealy detector SHALL:
- recognise "101" with overlap,
- assert `qout` combinationally in the cycle the final '1' is presented.
REQ-018 `match_cnt` SHALL increment at the clock edge of every SHIFT cycle in which `qout` = 1 (maximum 3 per frame; no saturation logic required).
REQ-019 DONE SHALL last exactly 1 cycle, pulse `done` and drive `done_id`, then return to IDLE.
REQ-020 Latency: with `req` first seen high in IDLE at cycle n:
- GRANT SHALL occur at n+1,
- SHIFT SHALL occur at n+2..n+9,
- DONE SHALL occur at n+10,
- the earliest next GRANT SHALL be at n+12.
REQ-021 `req` and `frame_bus` changes after GRANT SHALL be ignored; a frame always completes once granted.
REQ-022 Outside SHIFT, `din_s` and `qout` SHALL be 0.
REQ-023 Simultaneous requests SHALL be resolved by the arbitration policy of REQ-027/REQ-028; losers SHALL be served only after re-arbitration in IDLE.

Reset
REQ-024 When `rst` = 1 at a rising edge, the block SHALL enter IDLE from any state, including mid-SHIFT, and abort the frame without asserting `done`.
REQ-025 The reset values SHALL be:
- `gnt` = 0, `busy` = 0, `done` = 0, `done_id` = 0, `match_cnt` = 0,
- detector at start state,
- round-robin pointer = 0.

Configuration
REQ-026 The macro `ROUND_ROBIN_EN` SHALL select the arbitration policy.
REQ-027 With `ROUND_ROBIN_EN` defined, arbitration SHALL be round-robin:
- the search SHALL start at pointer p,
- on each grant, p SHALL become winner+1 mod 4,
- the most recently served requester SHALL have lowest priority.
REQ-028 Without `ROUND_ROBIN_EN`, arbitration SHALL be fixed priority, `req[0]` highest and `req[3]` lowest, and no pointer register shall be present.

Verification
REQ-029 Scenario, basic frame:
- Stimulus: `req` = 4'b0001, frame0 = 8'b10101101.
- Response: `gnt` = 0001 at n+1; `qout` pulses on bits 3, 5 and 8; `done` at n+10 with `done_id` = 0 and `match_cnt` = 3.
REQ-030 Scenario, no match:
- Stimulus: frame = 8'hFF.
- Response: `match_cnt` = 0 and `qout` never high.
REQ-031 Scenario, single match without spill into the next frame:
- Stimulus: frame A = 8'b00000101, then frame B = 8'b01000000 from the same requester.
- Response: A gives `match_cnt` = 1; B gives 0, because the detector is reset between frames.
REQ-032 Scenario, contention:
- Stimulus: `req` = 4'b1111 held.
- Response with `ROUND_ROBIN_EN`: grant order 0,1,2,3,0.
- Response without `ROUND_ROBIN_EN`: grant order 0,0,0.
REQ-033 Scenario, reset mid-frame:
- Stimulus: `rst` = 1 for one cycle at SHIFT cycle 4.
- Response: next cycle `busy` = 0, `gnt` = 0, `match_cnt` = 0; no `done` pulse.
REQ-034 Scenario, request dropped after grant:
- Stimulus: `req` drops to 0 during SHIFT.
- Response: the frame still completes; `done` asserts at n+10.
